// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer: FSM state encoding,
// legal channel-count bounds and the channel-index width function.
package tdm_pkg;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  // Width of the channel index for nch channels (at least one bit).
  function automatic int ch_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/tdm_chan_cnt.sv
// Modulo-NCH channel counter. Priority: clr, then load1, then inc.
// wrap flags the increment that rolls NCH-1 back to 0.
module tdm_chan_cnt #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load1,
  input  logic            clr,
  output logic [CH_W-1:0] ch,
  output logic            wrap
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NCH - 1);

  logic [CH_W-1:0] ch_q;

  assign ch   = ch_q;
  assign wrap = inc && (ch_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q <= '0;
    end else if (clr) begin
      ch_q <= '0;
    end else if (load1) begin
      ch_q <= CH_W'(1);
    end else if (inc) begin
      ch_q <= wrap ? '0 : ch_q + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: steers an interleaved beat stream into per-channel output
// registers and tracks frame alignment. TDM_DEMUX_FRAME_LATCH_EN selects whole-frame update.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [W-1:0]     in_data,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err,
  output logic             dbg_state
);

  localparam int CH_W = ch_width(NCH);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("tdm_demux: NCH out of legal range");
  end

  // Input handshake: a beat is consumed on every edge where in_valid=1; there is
  // no backpressure, and in_sof is ignored whenever in_valid=0.
  tdm_state_e        state_q, state_d;
  logic [CH_W-1:0]   ch;
  logic              wrap;
  logic              cnt_inc, cnt_load1, cnt_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic              sync_err_d;
  logic [NCH*W-1:0]  out_data_q, out_data_d;
  logic [NCH-1:0]    out_valid_q, out_valid_d;
  logic              frame_done_q, sync_err_q, locked_q;

  tdm_chan_cnt #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .ch    (ch),
    .wrap  (wrap)
  );

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_ch      = '0;
    cnt_inc    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;
    sync_err_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sof) begin
            wr_en     = 1'b1;
            cnt_load1 = 1'b1;
            state_d   = LOCK;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        LOCK: begin
          wr_en = 1'b1;
          if (in_sof) begin
            // SOF always realigns to channel 0; off-boundary it abandons the frame.
            cnt_load1  = 1'b1;
            sync_err_d = (ch != '0);
          end else begin
            wr_ch   = ch;
            cnt_inc = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [NCH*W-1:0] shadow_q, shadow_d;

  // Beats collect in the shadow; a completed frame is published in one cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[int'(wr_ch)*W +: W] = in_data;
    end
    out_data_d  = wrap ? shadow_d : out_data_q;
    out_valid_d = wrap ? '1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = '0;
    if (wr_en) begin
      out_data_d[int'(wr_ch)*W +: W] = in_data;
      out_valid_d[wr_ch]             = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= wrap;
      sync_err_q   <= sync_err_d;
      locked_q     <= (state_d == LOCK);
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = locked_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: channel-array reference model checked every cycle,
// plus directed frames with literal expectations. Honours TDM_DEMUX_FRAME_LATCH_EN.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic             frame_done, locked, sync_err, dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]   m_data[NCH];
  logic [W-1:0]   m_sh[NCH];
  logic [NCH-1:0] m_valid;
  bit             m_lock, m_fd, m_se;
  int             m_ch;

  function automatic logic [NCH*W-1:0] m_flat();
    logic [NCH*W-1:0] f;
    for (int k = 0; k < NCH; k++) f[k*W +: W] = m_data[k];
    return f;
  endfunction

  initial begin
    int tgt;
    bit done;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_lock = 0; m_ch = 0; m_valid = '0; m_fd = 0; m_se = 0;
        for (int k = 0; k < NCH; k++) begin
          m_data[k] = '0;
          m_sh[k]   = '0;
        end
      end else begin
        m_valid = '0; m_fd = 0; m_se = 0;
        tgt = -1; done = 0;
        if (in_valid) begin
          if (!m_lock) begin
            if (in_sof) begin tgt = 0; m_lock = 1; m_ch = 1; end
          end else if (in_sof) begin
            m_se = (m_ch != 0);
            tgt  = 0;
            m_ch = 1;
          end else begin
            tgt  = m_ch;
            done = (m_ch == NCH - 1);
            m_ch = (m_ch + 1) % NCH;
          end
        end
        if (tgt >= 0) begin
          if (LATCH) begin
            m_sh[tgt] = in_data;
            if (done) begin
              for (int k = 0; k < NCH; k++) m_data[k] = m_sh[k];
              m_valid = '1;
            end
          end else begin
            m_data[tgt]  = in_data;
            m_valid[tgt] = 1'b1;
          end
          m_fd = done;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_data",  out_data,   m_flat());
      chk("cyc_valid", out_valid,  m_valid);
      chk("cyc_fd",    frame_done, m_fd);
      chk("cyc_lock",  locked,     m_lock);
      chk("cyc_serr",  sync_err,   m_se);
    end
  end

  // ---------------- drivers ----------------
  task automatic beat(input logic sof, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input logic sof, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = sof;
      in_data  = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  out_data,   '0);
    chk("rst_valid", out_valid,  '0);
    chk("rst_lock",  locked,     1'b0);
    chk("rst_fd",    frame_done, 1'b0);
    chk("rst_serr",  sync_err,   1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Frame A0..D3 back to back
    beat(1'b1, 8'hA0);
    chk("s1_v0",   out_valid, LATCH ? 4'b0000 : 4'b0001);
    chk("s1_d0",   out_data,  LATCH ? 32'h0 : 32'h000000A0);
    chk("s1_lock", locked,    1'b1);
    beat(1'b0, 8'hB1);
    chk("s1_v1",   out_valid, LATCH ? 4'b0000 : 4'b0010);
    beat(1'b0, 8'hC2);
    chk("s1_v2",   out_valid, LATCH ? 4'b0000 : 4'b0100);
    chk("s1_fd2",  frame_done, 1'b0);
    beat(1'b0, 8'hD3);
    chk("s1_v3",   out_valid, LATCH ? 4'b1111 : 4'b1000);
    chk("s1_fd3",  frame_done, 1'b1);
    chk("s1_data", out_data,  32'hD3C2B1A0);
    gap(1'b0, 1);
    chk("s1_idle", out_valid, 4'b0000);

    // Beats without SOF in HUNT are discarded
    pulse_reset();
    beat(1'b0, 8'h11);
    chk("s2_v11",  out_valid, 4'b0000);
    chk("s2_lock", locked,    1'b0);
    beat(1'b0, 8'h22);
    chk("s2_v22",  out_valid, 4'b0000);
    chk("s2_d22",  out_data,  32'h0);
    beat(1'b1, 8'h33);
    beat(1'b0, 8'h44);
    beat(1'b0, 8'h55);
    beat(1'b0, 8'h66);
    chk("s2_data", out_data,  32'h66554433);
    chk("s2_fd",   frame_done, 1'b1);

    // Misaligned SOF aborts the partial frame and resyncs
    beat(1'b1, 8'h01);
    beat(1'b0, 8'h02);
    beat(1'b1, 8'h99);
    chk("s3_serr", sync_err,   1'b1);
    chk("s3_fd",   frame_done, 1'b0);
    chk("s3_d99",  out_data,   LATCH ? 32'h66554433 : 32'h66550299);
    chk("s3_v99",  out_valid,  LATCH ? 4'b0000 : 4'b0001);
    beat(1'b0, 8'h77);
    chk("s3_v77",  out_valid,  LATCH ? 4'b0000 : 4'b0010);
    chk("s3_d77",  out_data,   LATCH ? 32'h66554433 : 32'h66557799);
    chk("s3_serr2", sync_err,  1'b0);
    beat(1'b0, 8'h88);
    beat(1'b0, 8'hAA);
    chk("s3_data", out_data,   32'hAA887799);
    chk("s3_fdon", frame_done, 1'b1);

    // Gap with in_sof=1 between channels 1 and 2
    beat(1'b1, 8'hC0);
    beat(1'b0, 8'hC1);
    gap(1'b1, 3);
    chk("s4_gap_v",  out_valid, 4'b0000);
    chk("s4_gap_d",  out_data,  LATCH ? 32'hAA887799 : 32'hAA88C1C0);
    chk("s4_gap_se", sync_err,  1'b0);
    chk("s4_gap_lk", locked,    1'b1);
    beat(1'b0, 8'hC2);
    chk("s4_v2",     out_valid, LATCH ? 4'b0000 : 4'b0100);
    beat(1'b0, 8'hC3);
    chk("s4_data",   out_data,  32'hC3C2C1C0);
    chk("s4_fd",     frame_done, 1'b1);

    // Asynchronous reset mid-frame
    beat(1'b1, 8'hE0);
    beat(1'b0, 8'hE1);
    chk("s5_pre", out_data, LATCH ? 32'hC3C2C1C0 : 32'hC3C2E1E0);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("s5_rdata", out_data,  32'h0);
    chk("s5_rlock", locked,    1'b0);
    chk("s5_rvld",  out_valid, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 8'hF0);
    beat(1'b0, 8'hF1);
    beat(1'b0, 8'hF2);
    beat(1'b0, 8'hF3);
    chk("s5_data", out_data,   32'hF3F2F1F0);
    chk("s5_fd",   frame_done, 1'b1);

    // Missing SOF at a frame boundary is accepted as channel 0
    beat(1'b0, 8'h5A);
    chk("s6_v",    out_valid, LATCH ? 4'b0000 : 4'b0001);
    chk("s6_data", out_data,  LATCH ? 32'hF3F2F1F0 : 32'hF3F2F15A);
    chk("s6_serr", sync_err,  1'b0);
    gap(1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
